cla_nibble_serial_adder: RTL and testbench



---
 rtl/cla_nibble_serial_adder.sv | 135 +++++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle add/subtract: streams WIDTH-bit operands one nibble per clock
// through a single 4-bit carry-lookahead slice, carry held between steps.

module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] g, p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // All carries flattened from g/p/c_in so none ripples through another.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s     = p ^ c[3:0];
    assign c_out = c[4];
endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int N      = WIDTH / 4;
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              carry_q, carry_d, ovf_q, ovf_d;
    logic              accept, last;
    logic [3:0]        sl_s;
    logic              sl_co;

    assign last   = (step_q == STEP_W'(N - 1));
    assign accept = start && (state_q != RUN);

    // Operands shift right each step so the slice always sees bits [3:0].
    cla4_slice u_slice (
        .a     (a_q[3:0]),
        .b     (b_q[3:0]),
        .c_in  (carry_q),
        .s     (sl_s),
        .c_out (sl_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        step_d  = step_q;
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            step_d  = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            // Result fills from the top; after N steps nibble 0 lands at [3:0].
            sum_d   = (sum_q >> 4) | (WIDTH'(sl_s) << (WIDTH - 4));
            carry_d = sl_co;
            step_d  = step_q + 1'b1;
            if (last)
                ovf_d = (a_q[3] == b_q[3]) && (sl_s[3] != a_q[3]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            step_q  <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            step_q  <= step_d;
        end
    end

    assign sum      = sum_q;
    assign c_out    = carry_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for cla_nibble_serial_adder (WIDTH=16): results queued at
// accept time and compared when done pulses.

module tb_cla_nibble_serial_adder;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, sub;
    logic [W-1:0] a, b;
    logic         busy, done, c_out, overflow;
    logic [W-1:0] sum;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W-1:0] yp;
        logic [W:0]   full;
        exp_t         e;
        yp   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yp} + {{W{1'b0}}, s};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (x[W-1] == yp[W-1]) && (e.s[W-1] != x[W-1]);
        return e;
    endfunction

    // Called at a negedge; the following posedge is the accept edge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        a = x; b = y; sub = s; start = 1'b1;
        sb.push_back(model(x, y, s));
    endtask

    // cyc = negedges already elapsed since the accept edge.
    task automatic wait_done(input string tag, input int cyc0);
        int   cyc;
        exp_t e;
        cyc = cyc0;
        while (cyc < 20) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) chk({tag, "_busy1"}, 32'(busy), 32'd1);
            if (done) break;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd5);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e.s));
            chk({tag, "_cout"}, 32'(c_out), 32'(e.c));
            chk({tag, "_ovf"}, 32'(overflow), 32'(e.v));
        end
    endtask

    initial begin
        int   dcnt;
        exp_t held;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start = 1'b1;   // start coincident with rst must be ignored
        repeat (2) @(negedge clk);
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        start_op(16'h1234, 16'h4321, 1'b0); wait_done("add_basic", 0);
        @(negedge clk);
        chk("hold_done", 32'(done), 32'd0);
        chk("hold_sum", 32'(sum), 32'h5555);
        start_op(16'h0FFF, 16'h0001, 1'b0); wait_done("carry_chain", 0);
        start_op(16'hFFFF, 16'h0001, 1'b0); wait_done("wrap", 0);
        start_op(16'h7FFF, 16'h0001, 1'b0); wait_done("pos_ovf", 0);
        start_op(16'h8000, 16'h0001, 1'b1); wait_done("sub_ovf", 0);
        start_op(16'h0005, 16'h0007, 1'b1); wait_done("sub_borrow", 0);
        start_op(16'hA5C3, 16'h3C5A, 1'b1); wait_done("sub_mix", 0);

        // start during busy cycle 2 with other operands is ignored
        @(negedge clk);
        start_op(16'h1111, 16'h2222, 1'b0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("ignored_start", 3);
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_extra_done", 32'(dcnt), 32'd0);

        // back-to-back: start held in the DONE cycle
        start_op(16'h00FF, 16'h0F01, 1'b0); wait_done("b2b_first", 0);
        start_op(16'h4000, 16'h4000, 1'b0); wait_done("b2b_second", 0);
        @(negedge clk);

        // reset in RUN cycle 3 aborts the operation
        start_op(16'h1234, 16'h1111, 1'b0);
        held = sb.pop_front();
        repeat (3) begin
            @(negedge clk); start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        start_op(held.s, 16'h8001, 1'b1); wait_done("post_abort", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
